// File: rtl/warp_fetch_scheduler.sv
// Per-SM warp fetch scheduler: owns warp PCs and fetch state,
// issues one round-robin fetch request per cycle to the I-cache.
module warp_fetch_scheduler #(
  parameter int          NUM_WARPS = 4,
  parameter logic [31:0] RESET_PC  = 32'h0,
  localparam int         WID_W     = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_WARPS-1:0] warp_enable,
  input  logic [NUM_WARPS-1:0] ifq_full,
  input  logic                 start_valid,
  input  logic [WID_W-1:0]     start_warp,
  input  logic [31:0]          start_pc,
  input  logic                 branch_valid,
  input  logic [WID_W-1:0]     branch_warp,
  input  logic [31:0]          branch_pc,
  input  logic                 miss_valid,
  input  logic [WID_W-1:0]     miss_warp,
  input  logic [31:0]          miss_pc,
  input  logic                 fill_valid,
  input  logic [WID_W-1:0]     fill_warp,
  output logic                 fetch_valid,
  input  logic                 fetch_ready,
  output logic [WID_W-1:0]     fetch_warp,
  output logic [31:0]          fetch_pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READY,
    S_WAIT
  } wstate_e;

  wstate_e              r_state   [NUM_WARPS];
  wstate_e              w_state_nx[NUM_WARPS];
  logic [31:0]          r_pc      [NUM_WARPS];
  logic [31:0]          w_pc_nx   [NUM_WARPS];

  logic                 r_fetch_valid;
  logic [WID_W-1:0]     r_fetch_warp;
  logic [31:0]          r_fetch_pc;
  logic [WID_W-1:0]     r_last_grant;

  logic [NUM_WARPS-1:0] w_elig;
  logic                 w_found;
  logic [WID_W-1:0]     w_sel;
  logic                 w_load;
  logic [WID_W-1:0]     w_out_warp;
  logic                 w_out_act;
  logic [31:0]          w_fpc_nx;

  // Per-warp state and PC registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_state[w] <= S_IDLE;
        r_pc[w]    <= RESET_PC;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_state[w] <= w_state_nx[w];
        r_pc[w]    <= w_pc_nx[w];
      end
    end
  end

  // Eligibility, round-robin pick and output-register target
  always_comb begin
    logic [WID_W-1:0] w_idx;
    w_idx   = '0;
    w_found = 1'b0;
    w_sel   = r_last_grant;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_elig[w] = (r_state[w] == S_READY) && warp_enable[w] &&
                  !ifq_full[w] &&
                  !(r_fetch_valid && r_fetch_warp == WID_W'(w));
    end
    // Walk downward so the nearest warp after last_grant wins
    for (int i = NUM_WARPS; i >= 1; i--) begin
      w_idx = r_last_grant + WID_W'(i);
      if (w_elig[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
    w_load     = !r_fetch_valid || fetch_ready;
    w_out_warp = w_load ? w_sel : r_fetch_warp;
    w_out_act  = w_load ? w_found : r_fetch_valid;
    if (start_valid && start_warp == w_out_warp)
      w_fpc_nx = start_pc;
    else if (branch_valid && branch_warp == w_out_warp)
      w_fpc_nx = branch_pc;
    else if (w_load)
      w_fpc_nx = r_pc[w_sel];
    else
      w_fpc_nx = r_fetch_pc;
  end

  // Per-warp next state: start > branch > miss > fill
  always_comb begin
    logic v_on;
    for (int w = 0; w < NUM_WARPS; w++) begin
      v_on          = w_out_act && (w_out_warp == WID_W'(w));
      w_state_nx[w] = r_state[w];
      w_pc_nx[w]    = r_pc[w];
      if (v_on && w_load)
        w_pc_nx[w] = r_pc[w] + 32'd4;
      if (start_valid && start_warp == WID_W'(w)) begin
        w_state_nx[w] = S_READY;
        w_pc_nx[w]    = v_on ? start_pc + 32'd4 : start_pc;
      end else if (branch_valid && branch_warp == WID_W'(w)) begin
        w_pc_nx[w] = v_on ? branch_pc + 32'd4 : branch_pc;
        if (r_state[w] == S_WAIT)
          w_state_nx[w] = S_READY;
      end else if (miss_valid && miss_warp == WID_W'(w)) begin
        w_state_nx[w] = S_WAIT;
        w_pc_nx[w]    = miss_pc;
      end else if (fill_valid && fill_warp == WID_W'(w) &&
                   r_state[w] == S_WAIT) begin
        w_state_nx[w] = S_READY;
      end
    end
  end

  // Fetch output register with valid/ready hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_valid <= 1'b0;
      r_fetch_warp  <= '0;
      r_fetch_pc    <= '0;
      r_last_grant  <= WID_W'(NUM_WARPS - 1);
    end else if (w_load) begin
      r_fetch_valid <= w_found;
      if (w_found) begin
        r_fetch_warp <= w_sel;
        r_fetch_pc   <= w_fpc_nx;
        r_last_grant <= w_sel;
      end
    end else begin
      r_fetch_pc <= w_fpc_nx;
    end
  end

  assign fetch_valid = r_fetch_valid;
  assign fetch_warp  = r_fetch_warp;
  assign fetch_pc    = r_fetch_pc;

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Directed testbench for warp_fetch_scheduler (4 warps).
// Hand-computed grant/PC sequence checked after every edge.
module tb_warp_fetch_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  warp_enable;
  logic [3:0]  ifq_full;
  logic        start_valid;
  logic [1:0]  start_warp;
  logic [31:0] start_pc;
  logic        branch_valid;
  logic [1:0]  branch_warp;
  logic [31:0] branch_pc;
  logic        miss_valid;
  logic [1:0]  miss_warp;
  logic [31:0] miss_pc;
  logic        fill_valid;
  logic [1:0]  fill_warp;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [1:0]  fetch_warp;
  logic [31:0] fetch_pc;

  int n_assert = 0;
  int n_fail   = 0;

  warp_fetch_scheduler #(
    .NUM_WARPS(4),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .warp_enable (warp_enable),
    .ifq_full    (ifq_full),
    .start_valid (start_valid),
    .start_warp  (start_warp),
    .start_pc    (start_pc),
    .branch_valid(branch_valid),
    .branch_warp (branch_warp),
    .branch_pc   (branch_pc),
    .miss_valid  (miss_valid),
    .miss_warp   (miss_warp),
    .miss_pc     (miss_pc),
    .fill_valid  (fill_valid),
    .fill_warp   (fill_warp),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_warp  (fetch_warp),
    .fetch_pc    (fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_fetch(input string tag, input logic [1:0] w,
                           input logic [31:0] pc);
    chk({tag, ".valid"}, 32'(fetch_valid), 32'd1);
    chk({tag, ".warp"},  32'(fetch_warp),  32'(w));
    chk({tag, ".pc"},    fetch_pc,         pc);
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, ".valid"}, 32'(fetch_valid), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    warp_enable  = 4'b0000;
    ifq_full     = 4'b0000;
    start_valid  = 1'b0;
    start_warp   = 2'd0;
    start_pc     = 32'h0;
    branch_valid = 1'b0;
    branch_warp  = 2'd0;
    branch_pc    = 32'h0;
    miss_valid   = 1'b0;
    miss_warp    = 2'd0;
    miss_pc      = 32'h0;
    fill_valid   = 1'b0;
    fill_warp    = 2'd0;
    fetch_ready  = 1'b0;
    tick();
    tick();
    exp_idle("rst");
    chk("rst.warp", 32'(fetch_warp), 32'd0);
    chk("rst.pc", fetch_pc, 32'h0);
    reset = 1'b1;
    warp_enable = 4'b1111;
    fetch_ready = 1'b1;

    // Launch warps 0..3, one per cycle
    start_valid = 1'b1; start_warp = 2'd0; start_pc = 32'h100;
    tick();
    exp_idle("l0");
    start_warp = 2'd1; start_pc = 32'h200;
    tick();
    exp_fetch("g0", 2'd0, 32'h100);
    start_warp = 2'd2; start_pc = 32'h300;
    tick();
    exp_fetch("g1", 2'd1, 32'h200);
    start_warp = 2'd3; start_pc = 32'h400;
    tick();
    exp_fetch("g2", 2'd2, 32'h300);
    start_valid = 1'b0;
    tick();
    exp_fetch("g3", 2'd3, 32'h400);
    tick();
    exp_fetch("g4", 2'd0, 32'h104);

    // Backpressure hold on warp 1
    tick();
    exp_fetch("h0", 2'd1, 32'h204);
    fetch_ready = 1'b0;
    tick();
    exp_fetch("h1", 2'd1, 32'h204);
    tick();
    exp_fetch("h2", 2'd1, 32'h204);
    tick();
    exp_fetch("h3", 2'd1, 32'h204);
    fetch_ready = 1'b1;
    tick();
    exp_fetch("h4", 2'd2, 32'h304);

    // Miss on warp 2, fill five cycles later
    miss_valid = 1'b1; miss_warp = 2'd2; miss_pc = 32'h300;
    tick();
    exp_fetch("m0", 2'd3, 32'h404);
    miss_valid = 1'b0;
    tick();
    exp_fetch("m1", 2'd0, 32'h108);
    tick();
    exp_fetch("m2", 2'd1, 32'h208);
    tick();
    exp_fetch("m3skip", 2'd3, 32'h408);
    tick();
    exp_fetch("m4", 2'd0, 32'h10c);
    fill_valid = 1'b1; fill_warp = 2'd2;
    tick();
    exp_fetch("f0", 2'd1, 32'h20c);
    fill_valid = 1'b0;
    tick();
    exp_fetch("f1", 2'd2, 32'h300);

    // Branch rewrites held warp 1 in place
    tick();
    exp_fetch("b0", 2'd3, 32'h40c);
    tick();
    exp_fetch("b1", 2'd0, 32'h110);
    tick();
    exp_fetch("b2", 2'd1, 32'h210);
    fetch_ready = 1'b0;
    tick();
    exp_fetch("b3", 2'd1, 32'h210);
    branch_valid = 1'b1; branch_warp = 2'd1; branch_pc = 32'h800;
    tick();
    exp_fetch("b4", 2'd1, 32'h800);
    branch_valid = 1'b0;
    tick();
    exp_fetch("b5", 2'd1, 32'h800);
    fetch_ready = 1'b1;
    tick();
    exp_fetch("b6", 2'd2, 32'h304);
    tick();
    exp_fetch("b7", 2'd3, 32'h410);
    tick();
    exp_fetch("b8", 2'd0, 32'h114);
    tick();
    exp_fetch("b9", 2'd1, 32'h804);

    // Instruction-queue backpressure
    ifq_full = 4'b0101;
    tick();
    exp_fetch("q0", 2'd3, 32'h414);
    tick();
    exp_fetch("q1", 2'd1, 32'h808);
    tick();
    exp_fetch("q2", 2'd3, 32'h418);
    tick();
    exp_fetch("q3", 2'd1, 32'h80c);
    ifq_full = 4'b0100;
    tick();
    exp_fetch("q4", 2'd3, 32'h41c);
    tick();
    exp_fetch("q5", 2'd0, 32'h118);
    tick();
    exp_fetch("q6", 2'd1, 32'h810);
    ifq_full = 4'b0000;

    // Same-cycle miss + branch on warp 3: branch wins
    miss_valid = 1'b1; miss_warp = 2'd3; miss_pc = 32'h400;
    branch_valid = 1'b1; branch_warp = 2'd3; branch_pc = 32'h900;
    tick();
    exp_fetch("mb0", 2'd2, 32'h308);
    miss_valid = 1'b0;
    branch_valid = 1'b0;
    tick();
    exp_fetch("mb1", 2'd3, 32'h900);

    // Miss on held warp keeps fetch_pc
    fetch_ready = 1'b0;
    miss_valid = 1'b1; miss_warp = 2'd3; miss_pc = 32'h950;
    tick();
    exp_fetch("mh0", 2'd3, 32'h900);
    miss_valid = 1'b0;
    fetch_ready = 1'b1;
    tick();
    exp_fetch("mh1", 2'd0, 32'h11c);
    fill_valid = 1'b1; fill_warp = 2'd3;
    tick();
    exp_fetch("mh2", 2'd1, 32'h814);
    fill_valid = 1'b0;
    tick();
    exp_fetch("mh3", 2'd2, 32'h30c);
    tick();
    exp_fetch("mh4", 2'd3, 32'h950);

    // Branch in the same cycle the warp is loaded
    branch_valid = 1'b1; branch_warp = 2'd0; branch_pc = 32'ha00;
    tick();
    exp_fetch("bl0", 2'd0, 32'ha00);
    branch_valid = 1'b0;
    tick();
    exp_fetch("bl1", 2'd1, 32'h818);
    tick();
    exp_fetch("bl2", 2'd2, 32'h310);
    tick();
    exp_fetch("bl3", 2'd3, 32'h954);
    tick();
    exp_fetch("bl4", 2'd0, 32'ha04);

    // Asynchronous reset mid-stream
    reset = 1'b0;
    #1;
    exp_idle("ar0");
    chk("ar0.warp", 32'(fetch_warp), 32'd0);
    chk("ar0.pc", fetch_pc, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    exp_idle("ar1");
    tick();
    exp_idle("ar2");
    start_valid = 1'b1; start_warp = 2'd1; start_pc = 32'h40;
    tick();
    start_valid = 1'b0;
    exp_idle("ar3");
    tick();
    exp_fetch("ar4", 2'd1, 32'h40);
    tick();
    exp_idle("ar5");
    tick();
    exp_fetch("ar6", 2'd1, 32'h44);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
